// File: rtl/receptor_requisicao_pkg.sv
// Shared definitions for the request receiver, dispatcher and sensor modules:
// FSM encoding, address width and the reserved-bit mask of the address byte.
package receptor_requisicao_pkg;

    localparam int ADDR_W = 5;
    localparam logic [7:0] RSV_MASK = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ADDR = 2'd1,
        ST_EMIT      = 2'd2
    } rx_state_e;

    function automatic logic addr_byte_ok(input logic [7:0] b, input int max_addr);
        return ((b & RSV_MASK) == 8'h00) && (int'(b[ADDR_W-1:0]) <= max_addr);
    endfunction

endpackage

// File: rtl/receptor_requisicao_timeout_contador.sv
// Inter-byte idle counter: runs while run_i is high, held at zero otherwise;
// expired_o flags the last allowed idle cycle (count == TIMEOUT_CYCLES-1).
module timeout_contador #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = '0;
        if (run_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = run_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/receptor_requisicao.sv
// Two-byte (command, address) frame receiver; result strobes one cycle after the address byte.
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module receptor_requisicao
    import receptor_requisicao_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int MAX_ADDR       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        cmd_out,
    output logic [ADDR_W-1:0] addres_req,
    output logic              uart_rx_ready,
    output logic              frame_err,
    output logic              busy
);

    rx_state_e         state_q, state_d;
    logic [7:0]        cmd_hold_q, cmd_hold_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic              addr_ok;
    logic              timeout_hit;

    assign addr_ok = addr_byte_ok(rx_data, MAX_ADDR);

`ifdef RX_TIMEOUT_EN
    timeout_contador #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .run_i     (state_q == ST_WAIT_ADDR),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cmd_hold_q <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_hold_q <= cmd_hold_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
        end
    end

    // rx_valid wins over an expiring timeout in WAIT_ADDR
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) state_d = ST_WAIT_ADDR;
            end
            ST_WAIT_ADDR: begin
                if (rx_valid)         state_d = addr_ok ? ST_EMIT : ST_IDLE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            ST_EMIT: begin
                state_d = rx_valid ? ST_WAIT_ADDR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_hold_d = cmd_hold_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        err_d      = 1'b0;
        if (state_q == ST_WAIT_ADDR) begin
            if (rx_valid) begin
                if (addr_ok) begin
                    cmd_d  = cmd_hold_q;
                    addr_d = rx_data[ADDR_W-1:0];
                end else begin
                    err_d = 1'b1;
                end
            end else if (timeout_hit) begin
                err_d = 1'b1;
            end
        end else if (rx_valid) begin
            cmd_hold_d = rx_data;
        end
    end

    always_comb begin
        uart_rx_ready = (state_q == ST_EMIT);
        busy          = (state_q == ST_WAIT_ADDR);
        frame_err     = err_q;
        cmd_out       = cmd_q;
        addres_req    = addr_q;
    end

endmodule

// File: tb/tb_receptor_requisicao.sv
// Randomised and directed bench for receptor_requisicao against a frame-level reference model.
module tb_receptor_requisicao;

    localparam int TO_CYC = 16;
    localparam int MAXA   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] cmd_out;
    logic [4:0] addres_req;
    logic       uart_rx_ready;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    receptor_requisicao #(
        .TIMEOUT_CYCLES (TO_CYC),
        .MAX_ADDR       (MAXA)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .cmd_out       (cmd_out),
        .addres_req    (addres_req),
        .uart_rx_ready (uart_rx_ready),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Frame-level model: a pending command byte or nothing, plus last accepted frame.
    logic       m_have;
    logic [7:0] m_cmd;
    int         m_idle;
    logic [7:0] m_cmd_out;
    logic [4:0] m_addr;
    logic       m_ready;
    logic       m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_have    <= 1'b0;
            m_cmd     <= 8'h00;
            m_idle    <= 0;
            m_cmd_out <= 8'h00;
            m_addr    <= 5'd0;
            m_ready   <= 1'b0;
            m_err     <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            if (rx_valid) begin
                if (!m_have) begin
                    m_have <= 1'b1;
                    m_cmd  <= rx_data;
                    m_idle <= 0;
                end else begin
                    m_have <= 1'b0;
                    if (rx_data[7:5] == 3'b000 && int'(rx_data[4:0]) <= MAXA) begin
                        m_cmd_out <= m_cmd;
                        m_addr    <= rx_data[4:0];
                        m_ready   <= 1'b1;
                    end else begin
                        m_err <= 1'b1;
                    end
                end
            end else if (m_have) begin
`ifdef RX_TIMEOUT_EN
                if (m_idle + 1 >= TO_CYC) begin
                    m_have <= 1'b0;
                    m_err  <= 1'b1;
                end else
`endif
                m_idle <= m_idle + 1;
            end
        end
    end

    logic       chk_en;
    logic       lit_en;
    logic [7:0] lit_cmd;
    logic [4:0] lit_addr;
    logic       lit_rdy, lit_err, lit_busy;

    task automatic cmp(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cmd_out",   cmd_out,                {3'b000, m_addr} == 8'hFF ? 8'h00 : m_cmd_out);
            cmp("addr",      {3'b000, addres_req},   {3'b000, m_addr});
            cmp("ready",     {7'd0, uart_rx_ready},  {7'd0, m_ready});
            cmp("frame_err", {7'd0, frame_err},      {7'd0, m_err});
            cmp("busy",      {7'd0, busy},           {7'd0, m_have});
            cmp("rdy_err_excl", {7'd0, uart_rx_ready & frame_err}, 8'h00);
            if (lit_en) begin
                cmp("lit_cmd",   cmd_out,               lit_cmd);
                cmp("lit_addr",  {3'b000, addres_req},  {3'b000, lit_addr});
                cmp("lit_ready", {7'd0, uart_rx_ready}, {7'd0, lit_rdy});
                cmp("lit_err",   {7'd0, frame_err},     {7'd0, lit_err});
                cmp("lit_busy",  {7'd0, busy},          {7'd0, lit_busy});
            end
        end
    end

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic lit(input logic [7:0] c, input logic [4:0] a,
                       input logic r, input logic e, input logic b);
        lit_cmd  = c;
        lit_addr = a;
        lit_rdy  = r;
        lit_err  = e;
        lit_busy = b;
        lit_en   = 1'b1;
        @(negedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        chk_en   = 1'b0;
        lit_en   = 1'b0;
        lit_cmd  = 8'h00;
        lit_addr = 5'd0;
        lit_rdy  = 1'b0;
        lit_err  = 1'b0;
        lit_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit(8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Basic frame
        tick(1'b1, 8'h01); lit(8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'h03); lit(8'h01, 5'd3, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00); lit(8'h01, 5'd3, 1'b0, 1'b0, 1'b0);

        // Reserved bits set
        tick(1'b1, 8'h02);
        tick(1'b1, 8'h29); lit(8'h01, 5'd3, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 8'h00); lit(8'h01, 5'd3, 1'b0, 1'b0, 1'b0);

        // Address above MAX_ADDR
        tick(1'b1, 8'h01);
        tick(1'b1, 8'h09); lit(8'h01, 5'd3, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 8'h00);

        // Back-to-back, new command during EMIT, boundary address 8
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h04); lit(8'h11, 5'd4, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'h22); lit(8'h11, 5'd4, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'h08); lit(8'h22, 5'd8, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00);

        // Address byte arriving on the last allowed idle cycle is accepted
        tick(1'b1, 8'h06);
        repeat (TO_CYC - 1) tick(1'b0, 8'h00);
        tick(1'b1, 8'h01); lit(8'h06, 5'd1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00);

        // Idle gap after the command byte
`ifdef RX_TIMEOUT_EN
        tick(1'b1, 8'h05);
        repeat (TO_CYC - 1) tick(1'b0, 8'h00);
        lit(8'h06, 5'd1, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00); lit(8'h06, 5'd1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 8'h05);
        tick(1'b1, 8'h00); lit(8'h05, 5'd0, 1'b1, 1'b0, 1'b0);
`else
        tick(1'b1, 8'h05);
        repeat (TO_CYC + 4) tick(1'b0, 8'h00);
        lit(8'h06, 5'd1, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'h00); lit(8'h05, 5'd0, 1'b1, 1'b0, 1'b0);
`endif
        tick(1'b0, 8'h00);

        // Reset mid-frame clears outputs immediately
        tick(1'b1, 8'h33);
        rst = 1'b1;
        lit(8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b1, 8'h07); lit(8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'h02); lit(8'h07, 5'd2, 1'b1, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [7:0]  d;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1;
                tick(1'b0, 8'h00);
                rst = 1'b0;
            end else if (r < 5) begin
                repeat (TO_CYC + 2) tick(1'b0, 8'h00);
            end else begin
                d = 8'($urandom);
                if ($urandom_range(0, 9) < 7) begin
                    d[7:5] = 3'b000;
                    d[4:0] = 5'($urandom_range(0, 10));
                end
                tick(1'($urandom_range(0, 1)), d);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receptor_requisicao.md
RECEPTOR_REQUISICAO -- requirements
Module: receptor_requisicao

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, the number of inter-byte idle cycles after which a partial frame is abandoned.
REQ-002 SHALL have parameter MAX_ADDR, default 8, the highest sensor address accepted.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port rx_data, input, 8 bits: received byte from the UART receiver.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe, rx_data valid.
REQ-007 SHALL have port cmd_out, output, 8 bits: command byte of the last accepted frame.
REQ-008 SHALL have port addres_req, output, 5 bits: sensor address of the last accepted frame, fed to the dispatcher.
REQ-009 SHALL have port uart_rx_ready, output, 1 bit: one-cycle strobe, frame complete, fed to the dispatcher.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle strobe, frame rejected.
REQ-011 SHALL have port busy, output, 1 bit: high while the command byte is held awaiting the address byte.

Function
REQ-012 SHALL implement frame = byte 0 command, byte 1 address; address byte bits[4:0] = address, bits[7:5] reserved.
REQ-013 SHALL implement states IDLE, WAIT_ADDR, EMIT, with encoding defined in the shared package.
REQ-014 SHALL, in IDLE on rx_valid, capture rx_data into a command holding register and go to WAIT_ADDR.
REQ-015 SHALL, in WAIT_ADDR on rx_valid with bits[7:5]=000 and bits[4:0] <= MAX_ADDR, load cmd_out/addres_req and go to EMIT.
REQ-016 SHALL, in WAIT_ADDR on rx_valid with nonzero reserved bits or address > MAX_ADDR, pulse frame_err the next cycle, leave cmd_out/addres_req unchanged, and go to IDLE.
REQ-017 SHALL, in EMIT, assert uart_rx_ready for exactly one cycle; latency is 1 cycle from the address-byte rx_valid edge to uart_rx_ready high.
REQ-018 SHALL keep cmd_out/addres_req stable from the uart_rx_ready cycle until the next accepted frame.
REQ-019 SHALL, on rx_valid during EMIT, treat that byte as the command byte of a new frame (capture it, go to WAIT_ADDR); no byte is dropped.
REQ-020 SHALL drive busy high exactly in WAIT_ADDR.
REQ-021 SHALL never assert uart_rx_ready and frame_err in the same cycle.

Reset
REQ-022 SHALL, on rst high, immediately go to IDLE and force cmd_out=0, addres_req=0, uart_rx_ready=0, frame_err=0, busy=0, and clear the timeout counter; a partial frame is discarded.
REQ-023 SHALL ignore rx_valid in the first edge after rst deasserts only if coincident with deassertion; a later rx_valid is processed normally.

Configuration
REQ-024 SHALL, with RX_TIMEOUT_EN defined, count cycles in WAIT_ADDR (cleared on entry); when the count reaches TIMEOUT_CYCLES-1 without rx_valid, go to IDLE and pulse frame_err the next cycle.
REQ-025 SHALL give rx_valid priority over timeout when both occur in the same cycle (the byte is accepted as the address).
REQ-026 SHALL, without RX_TIMEOUT_EN, omit the counter entirely and remain in WAIT_ADDR indefinitely.

Structure
REQ-027 SHALL place the state encoding, the reserved-bit mask and the address width (5) in a shared package used by the dispatcher and sensor modules.
REQ-028 SHALL place the inter-byte timeout counter in sub-module timeout_contador, instantiated only under RX_TIMEOUT_EN.

Verification
REQ-029 SHALL cover: bytes 0x01, 0x03 -> uart_rx_ready one cycle after 2nd strobe, cmd_out=0x01, addres_req=3.
REQ-030 SHALL cover: bytes 0x02, 0x29 (reserved bits set) -> frame_err one pulse, no uart_rx_ready, outputs unchanged.
REQ-031 SHALL cover: bytes 0x01, 0x09 with MAX_ADDR=8 -> frame_err pulse, FSM in IDLE.
REQ-032 SHALL cover: back-to-back frames, new command strobed in the EMIT cycle -> two uart_rx_ready pulses, both frames correct.
REQ-033 SHALL cover, with RX_TIMEOUT_EN and TIMEOUT_CYCLES=16: byte 0x05 then 16 idle cycles -> frame_err pulse, busy low; the next two bytes 0x05, 0x00 -> addres_req=0.
REQ-034 SHALL cover: rst asserted mid-frame in WAIT_ADDR -> all outputs 0 at once; the next byte is treated as a command.
